// File: rtl/cla_lab_pkg.sv
// Shared definitions for the CLA adder sweep checker: FSM encodings,
// default geometry and the vector-width helper.
package cla_lab_pkg;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_SETTLE = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Width of one {cin, a, b} vector for a given operand width.
  function automatic int vw(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/cla_sweep_checker_if.sv
// Bundle between the sweep checker and the adder under test plus the
// start/status signals seen by whoever launches a sweep.
interface cla_sweep_checker_if
  import cla_lab_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  localparam int VW = vw(WIDTH);

  logic             start;
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_s;
  logic             dut_cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [VW:0]      err_count;
  logic             fail_valid;
  logic [VW-1:0]    fail_vec;
  logic [WIDTH:0]   fail_got;

  // Checker side: drives operands and status, observes the adder result.
  modport master (
    input  start, dut_s, dut_cout,
    output dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, fail_valid, fail_vec, fail_got
  );

  // Adder / controller side.
  modport slave (
    output start, dut_s, dut_cout,
    input  dut_a, dut_b, dut_cin, busy, done, pass,
           err_count, fail_valid, fail_vec, fail_got
  );

endinterface

// File: rtl/cla_vector_sweep.sv
// Vector counter for the sweep. The counter is laid out as {cin, a, b}, so
// a plain increment walks B fastest, then A, then Cin.
module cla_vector_sweep #(
  parameter int VW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [VW-1:0] vec,
  output logic          last
);

  localparam logic [VW-1:0] VEC_ONE = VW'(1);

  logic [VW-1:0] vec_q;
  logic [VW-1:0] vec_d;

  // Next vector: clear wins over step so a restart always begins at zero.
  always_comb begin
    vec_d = vec_q;
    if (clear) begin
      vec_d = '0;
    end else if (step) begin
      vec_d = vec_q + VEC_ONE;
    end
  end

  // Vector register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q <= '0;
    end else begin
      vec_q <= vec_d;
    end
  end

  assign vec  = vec_q;
  assign last = &vec_q;

endmodule

// File: rtl/cla_sweep_checker.sv
// Exhaustive sweep checker for a WIDTH-bit adder: applies every {cin,a,b},
// waits SETTLE cycles, compares {cout,s} against a golden sum, counts
// mismatches and latches the first failing vector.
module cla_sweep_checker
  import cla_lab_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input logic                  clk,
  input logic                  rst,
  cla_sweep_checker_if.master  bus
);

  localparam int VW = vw(WIDTH);
  // One extra count of headroom keeps a single-cycle settle counter legal.
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [VW:0]   ERR_ONE     = (VW + 1)'(1);

  logic [1:0]     state_q, state_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [VW:0]    err_q, err_d;
  logic           fail_valid_q, fail_valid_d;
  logic [VW-1:0]  fail_vec_q, fail_vec_d;
  logic [WIDTH:0] fail_got_q, fail_got_d;

  logic           vec_clear;
  logic           vec_step;
  logic [VW-1:0]  vec;
  logic           vec_last;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH:0]   golden;
  logic [WIDTH:0]   observed;
  logic             mismatch;

  cla_vector_sweep #(
    .VW (VW)
  ) u_sweep (
    .clk   (clk),
    .rst   (rst),
    .clear (vec_clear),
    .step  (vec_step),
    .vec   (vec),
    .last  (vec_last)
  );

  assign op_cin = vec[VW-1];
  assign op_a   = vec[2*WIDTH-1:WIDTH];
  assign op_b   = vec[WIDTH-1:0];

  // Golden sum is zero-extended so the carry lands in the top bit.
  always_comb begin
    golden   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
    observed = {bus.dut_cout, bus.dut_s};
    mismatch = (observed != golden);
  end

  // FSM, settle counter, error counter and first-failure capture.
  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_got_d   = fail_got_q;
    vec_clear    = 1'b0;
    vec_step     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          vec_clear    = 1'b1;
          settle_d     = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_got_d   = '0;
          state_d      = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + SETTLE_ONE;
        end
      end
      ST_CHECK: begin
        // The adder outputs are only looked at here; anything else on
        // dut_s/dut_cout is ignored.
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec;
            fail_got_d   = observed;
          end
        end
        if (vec_last) begin
          state_d = ST_DONE;
        end else begin
          vec_step = 1'b1;
          state_d  = ST_APPLY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
    end
  end

  // Operands come straight from the vector register, so they hold through
  // CHECK and keep the final all-ones vector in DONE.
  assign bus.dut_cin    = op_cin;
  assign bus.dut_a      = op_a;
  assign bus.dut_b      = op_b;
  assign bus.busy       = (state_q == ST_APPLY) || (state_q == ST_CHECK);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;
  assign bus.fail_got   = fail_got_q;

endmodule

// File: tb/tb_cla_sweep_checker.sv
// Bench for cla_sweep_checker: a behavioural adder with selectable faults
// feeds a default (WIDTH=4, SETTLE=2) and a small (WIDTH=2, SETTLE=1) checker.
module tb_cla_sweep_checker;

  localparam int LIMIT = 2000;

  logic clk;
  logic rst;
  int   mode4;   // 0 good, 1 cout stuck at 0, 2 s[0] inverted
  int   mode2;
  int   n_checks;
  int   n_err;

  cla_sweep_checker_if #(.WIDTH(4)) bus4 ();
  cla_sweep_checker_if #(.WIDTH(2)) bus2 ();

  cla_sweep_checker #(.WIDTH(4), .SETTLE(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.master)
  );

  cla_sweep_checker #(.WIDTH(2), .SETTLE(1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit adder with fault injection.
  logic [4:0] full4;
  always_comb begin
    full4 = {1'b0, bus4.dut_a} + {1'b0, bus4.dut_b} + {4'b0, bus4.dut_cin};
    if (mode4 == 1) full4[4] = 1'b0;
    if (mode4 == 2) full4[0] = ~full4[0];
    bus4.dut_cout = full4[4];
    bus4.dut_s    = full4[3:0];
  end

  // Behavioural 2-bit adder with fault injection.
  logic [2:0] full2;
  always_comb begin
    full2 = {1'b0, bus2.dut_a} + {1'b0, bus2.dut_b} + {2'b0, bus2.dut_cin};
    if (mode2 == 1) full2[2] = 1'b0;
    bus2.dut_cout = full2[2];
    bus2.dut_s    = full2[1:0];
  end

  typedef struct {
    int         mode;
    bit         repulse;
    int         exp_err;
    logic       exp_pass;
    logic       exp_fv;
    logic [8:0] exp_vec;
    logic [4:0] exp_got;
  } row_t;

  row_t rows[3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic start_pulse4(input bit hold);
    bus4.start = 1'b1;
    tick();
    if (!hold) bus4.start = 1'b0;
  endtask

  // Counts cycles after the start edge until done; bounded by LIMIT.
  task automatic wait_done4(input bit repulse, input bit hold, output int cycles);
    cycles = 0;
    while (bus4.done !== 1'b1 && cycles < LIMIT) begin
      if (!hold) bus4.start = repulse && (cycles == 10 || cycles == 500);
      tick();
      cycles++;
    end
    if (!hold) bus4.start = 1'b0;
  endtask

  task automatic check_idle4(input string name);
    check({name, "_vec"}, {23'd0, bus4.dut_cin, bus4.dut_a, bus4.dut_b}, 32'd0);
    check({name, "_flags"}, {28'd0, bus4.busy, bus4.done, bus4.pass, bus4.fail_valid}, 32'd0);
    check({name, "_err"}, {22'd0, bus4.err_count}, 32'd0);
    check({name, "_fail"}, {18'd0, bus4.fail_vec, bus4.fail_got}, 32'd0);
  endtask

  task automatic check_result4(input string name, input row_t r);
    check({name, "_err"}, {22'd0, bus4.err_count}, r.exp_err);
    check({name, "_pass"}, {31'd0, bus4.pass}, {31'd0, r.exp_pass});
    check({name, "_fv"}, {31'd0, bus4.fail_valid}, {31'd0, r.exp_fv});
    check({name, "_fvec"}, {23'd0, bus4.fail_vec}, {23'd0, r.exp_vec});
    check({name, "_fgot"}, {27'd0, bus4.fail_got}, {27'd0, r.exp_got});
  endtask

  initial begin
    int cyc;
    n_checks   = 0;
    n_err      = 0;
    mode4      = 0;
    mode2      = 0;
    bus4.start = 1'b0;
    bus2.start = 1'b0;
    rst        = 1'b1;

    rows[0] = '{mode: 0, repulse: 1'b1, exp_err: 0,   exp_pass: 1'b1, exp_fv: 1'b0, exp_vec: 9'h000, exp_got: 5'h00};
    rows[1] = '{mode: 1, repulse: 1'b0, exp_err: 256, exp_pass: 1'b0, exp_fv: 1'b1, exp_vec: 9'h01F, exp_got: 5'h00};
    rows[2] = '{mode: 2, repulse: 1'b0, exp_err: 512, exp_pass: 1'b0, exp_fv: 1'b1, exp_vec: 9'h000, exp_got: 5'h01};

    tick();
    tick();
    check_idle4("reset4");
    check("reset2_flags", {28'd0, bus2.busy, bus2.done, bus2.pass, bus2.fail_valid}, 32'd0);
    rst = 1'b0;
    tick();

    // Table: good adder (with ignored re-pulses), stuck cout, inverted s[0].
    for (int i = 0; i < 3; i++) begin
      mode4 = rows[i].mode;
      start_pulse4(1'b0);
      check($sformatf("row%0d_first", i),
            {22'd0, bus4.busy, bus4.done, bus4.dut_cin, bus4.dut_a, bus4.dut_b}, {22'd0, 2'b10, 9'h000});
      wait_done4(rows[i].repulse, 1'b0, cyc);
      check($sformatf("row%0d_len", i), cyc, 32'd1536);
      check($sformatf("row%0d_lastvec", i), {23'd0, bus4.dut_cin, bus4.dut_a, bus4.dut_b}, 32'h1FF);
      check($sformatf("row%0d_busy", i), {31'd0, bus4.busy}, 32'd0);
      check_result4($sformatf("row%0d", i), rows[i]);
      $display("row %0d mode=%0d len=%0d err=%0d pass=%0b fail_vec=%03h fail_got=%02h",
               i, rows[i].mode, cyc, bus4.err_count, bus4.pass, bus4.fail_vec, bus4.fail_got);
    end

    // Restart from DONE: results clear at once, the re-run matches.
    start_pulse4(1'b0);
    check("restart_clear", {20'd0, bus4.done, bus4.busy, bus4.fail_valid, bus4.err_count}, {20'd0, 3'b010, 10'd0});
    wait_done4(1'b0, 1'b0, cyc);
    check("restart_len", cyc, 32'd1536);
    check_result4("restart", rows[2]);
    $display("restart len=%0d err=%0d", cyc, bus4.err_count);

    // Reset mid-sweep after 100 cycles: 33 vectors already checked.
    start_pulse4(1'b0);
    for (int k = 0; k < 100; k++) tick();
    check("midsweep_err", {22'd0, bus4.err_count}, 32'd33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle4("midrst");
    tick();
    tick();
    check("midrst_stay_idle", {30'd0, bus4.busy, bus4.done}, 32'd0);
    mode4 = 0;
    start_pulse4(1'b0);
    wait_done4(1'b0, 1'b0, cyc);
    check("after_rst_len", cyc, 32'd1536);
    check_result4("after_rst", rows[0]);
    $display("after reset len=%0d err=%0d pass=%0b", cyc, bus4.err_count, bus4.pass);

    // start held high through DONE restarts on the next edge.
    start_pulse4(1'b1);
    wait_done4(1'b0, 1'b1, cyc);
    check("hold_len", cyc, 32'd1536);
    tick();
    check("hold_rerun", {30'd0, bus4.busy, bus4.done}, 32'b10);
    $display("held start len=%0d busy=%0b done=%0b", cyc, bus4.busy, bus4.done);
    bus4.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Small configuration: 32 vectors of 2 cycles each.
    for (int m = 1; m >= 0; m--) begin
      mode2 = m;
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      cyc = 0;
      while (bus2.done !== 1'b1 && cyc < LIMIT) begin
        tick();
        cyc++;
      end
      check($sformatf("small%0d_len", m), cyc, 32'd64);
      check($sformatf("small%0d_err", m), {26'd0, bus2.err_count}, (m == 1) ? 32'd16 : 32'd0);
      check($sformatf("small%0d_pass", m), {31'd0, bus2.pass}, (m == 1) ? 32'd0 : 32'd1);
      check($sformatf("small%0d_fail", m), {22'd0, bus2.fail_valid, bus2.fail_vec, bus2.fail_got},
            (m == 1) ? {22'd0, 1'b1, 5'h07, 3'h0} : 32'd0);
      $display("small mode=%0d len=%0d err=%0d pass=%0b fail_vec=%02h",
               m, cyc, bus2.err_count, bus2.pass, bus2.fail_vec);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
